// File: rtl/rt_mem_ctrl.sv
// rtl/rt_mem_ctrl.sv - racetrack sequencing controller with two-port round-robin arbiter (LiM operands when RT_CTRL_LIM_EN is defined)
`timescale 1ns/1ps
module rt_mem_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 2,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    // instruction port (read only)
    input  logic                  instr_req_i,
    input  logic [ADDR_WIDTH-1:0] instr_addr_i,
    output logic                  instr_gnt_o,
    output logic                  instr_rvalid_o,
    output logic [DATA_WIDTH-1:0] instr_rdata_o,
    output logic                  instr_err_o,
    // data port
    input  logic                  data_req_i,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [DATA_WIDTH-1:0] data_wdata_i,
    input  logic [DATA_WIDTH-1:0] data_mask_i,
    input  logic [2:0]            data_funct_i,
    input  logic                  data_range_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    output logic [DATA_WIDTH-1:0] data_rdata_o,
    output logic                  data_err_o,
    // datapath strobes
    output logic                  en_ab_o,
    output logic                  clk_m_o,
    output logic                  Bz_s_o,
    output logic                  write_pulse_o,
    output logic                  read_pulse_o,
    output logic                  write_en_data_o,
    output logic                  range_active_o,
    // datapath operands
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [3:0]            be_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic [DATA_WIDTH-1:0] mask_o,
    output logic [2:0]            funct_o,
    // datapath result
    input  logic [DATA_WIDTH-1:0] r_data_i,
    input  logic                  r_valid_i
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SHIFT_FWD  = 3'd1,
        ACCESS     = 3'd2,
        WAIT_VALID = 3'd3,
        SHIFT_BACK = 3'd4,
        RESP       = 3'd5
    } state_e;

    state_e                state_q, state_d;
    logic                  last_data_q, last_data_d;  // 1: data port was granted last
    logic                  win_data_q, win_data_d;    // 1: current transaction belongs to data port
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;              // shift count of the transaction
    logic [CNT_WIDTH-1:0]  sc_q, sc_d;                // shifts left in the current shift phase
    logic                  phase_q, phase_d;          // 0: clk_m high half, 1: clk_m low half
    logic [TW-1:0]         wait_q, wait_d;            // WAIT_VALID cycles already spent
    logic                  vld_q, vld_d;              // sticky r_valid_i seen
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  we_q, we_d;
    logic                  range_q, range_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            be_q, be_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] mask_q, mask_d;
    logic [2:0]            funct_q, funct_d;

    logic                  grant_instr, grant_data;
    logic [ADDR_WIDTH-1:0] op_addr;
    logic                  op_we;
    logic [3:0]            op_be;
    logic [DATA_WIDTH-1:0] op_wdata;
    logic [DATA_WIDTH-1:0] op_mask;
    logic [2:0]            op_funct;
    logic                  op_range;
    logic                  rsp;

    // Round-robin pick in IDLE; gated by reset so grants are 0 while held in reset
    always_comb begin
        grant_instr = 1'b0;
        grant_data  = 1'b0;
        if (state_q == IDLE && rstn_i) begin
            if (instr_req_i && data_req_i) begin
                grant_instr = last_data_q;
                grant_data  = ~last_data_q;
            end else begin
                grant_instr = instr_req_i;
                grant_data  = data_req_i;
            end
        end
    end

    // Operands of the port being granted; instruction fetches are plain full-word reads
    always_comb begin
        op_addr  = grant_data ? data_addr_i : instr_addr_i;
        op_we    = grant_data & data_we_i;
        op_be    = grant_data ? data_be_i : 4'hF;
        op_wdata = grant_data ? data_wdata_i : '0;
`ifdef RT_CTRL_LIM_EN
        op_mask  = grant_data ? data_mask_i : '1;
        op_funct = grant_data ? data_funct_i : 3'd0;
        op_range = grant_data & data_range_i;
`else
        op_mask  = '1;
        op_funct = 3'd0;
        op_range = 1'b0;
`endif
    end

`ifndef RT_CTRL_LIM_EN
    logic unused_lim;
    assign unused_lim = ^{data_mask_i, data_funct_i, data_range_i};
`endif

    // Next-state logic: track phases and capture of the read result
    always_comb begin
        state_d     = state_q;
        last_data_d = last_data_q;
        win_data_d  = win_data_q;
        cnt_d       = cnt_q;
        sc_d        = sc_q;
        phase_d     = phase_q;
        wait_d      = wait_q;
        vld_d       = vld_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        we_d        = we_q;
        range_d     = range_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        mask_d      = mask_q;
        funct_d     = funct_q;

        case (state_q)
            IDLE: begin
                if (grant_instr || grant_data) begin
                    win_data_d  = grant_data;
                    last_data_d = grant_data;
                    addr_d      = op_addr;
                    we_d        = op_we;
                    be_d        = op_be;
                    wdata_d     = op_wdata;
                    mask_d      = op_mask;
                    funct_d     = op_funct;
                    range_d     = op_range;
                    cnt_d       = op_addr[CNT_WIDTH-1:0];
                    sc_d        = op_addr[CNT_WIDTH-1:0];
                    phase_d     = 1'b0;
                    wait_d      = '0;
                    vld_d       = 1'b0;
                    err_d       = 1'b0;
                    rdata_d     = '0;
                    state_d     = (op_addr[CNT_WIDTH-1:0] != '0) ? SHIFT_FWD : ACCESS;
                end
            end
            SHIFT_FWD: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    if (sc_q == CNT_WIDTH'(1)) begin
                        sc_d    = cnt_q;
                        state_d = ACCESS;
                    end else begin
                        sc_d = sc_q - CNT_WIDTH'(1);
                    end
                end
            end
            ACCESS: begin
                phase_d = 1'b0;
                if (we_q) begin
                    state_d = (cnt_q == '0) ? RESP : SHIFT_BACK;
                end else begin
                    wait_d  = '0;
                    state_d = WAIT_VALID;
                    if (r_valid_i) begin
                        vld_d   = 1'b1;
                        rdata_d = r_data_i;
                    end
                end
            end
            WAIT_VALID: begin
                if (vld_q || r_valid_i) begin
                    if (!vld_q) begin
                        rdata_d = r_data_i;
                    end
                    vld_d   = 1'b1;
                    state_d = (cnt_q == '0) ? RESP : SHIFT_BACK;
                end else if (wait_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = (cnt_q == '0) ? RESP : SHIFT_BACK;
                end else begin
                    wait_d = wait_q + TW'(1);
                end
            end
            SHIFT_BACK: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    if (sc_q == CNT_WIDTH'(1)) begin
                        state_d = RESP;
                    end else begin
                        sc_d = sc_q - CNT_WIDTH'(1);
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and operand registers; reset abandons any shift in progress
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            last_data_q <= 1'b0;
            win_data_q  <= 1'b0;
            cnt_q       <= '0;
            sc_q        <= '0;
            phase_q     <= 1'b0;
            wait_q      <= '0;
            vld_q       <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            we_q        <= 1'b0;
            range_q     <= 1'b0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            mask_q      <= '0;
            funct_q     <= '0;
        end else begin
            state_q     <= state_d;
            last_data_q <= last_data_d;
            win_data_q  <= win_data_d;
            cnt_q       <= cnt_d;
            sc_q        <= sc_d;
            phase_q     <= phase_d;
            wait_q      <= wait_d;
            vld_q       <= vld_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            we_q        <= we_d;
            range_q     <= range_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            mask_q      <= mask_d;
            funct_q     <= funct_d;
        end
    end

    // Strobes and responses decoded from the current phase
    always_comb begin
        rsp             = (state_q == RESP);
        instr_gnt_o     = grant_instr;
        data_gnt_o      = grant_data;
        en_ab_o         = (state_q != IDLE);
        clk_m_o         = (state_q == SHIFT_FWD || state_q == SHIFT_BACK) && !phase_q;
        Bz_s_o          = (state_q == SHIFT_FWD);
        write_pulse_o   = (state_q == ACCESS) && we_q;
        write_en_data_o = (state_q == ACCESS) && we_q;
        read_pulse_o    = (state_q == ACCESS) && !we_q;
        range_active_o  = (state_q != IDLE) && range_q;
        instr_rvalid_o  = rsp && !win_data_q;
        data_rvalid_o   = rsp && win_data_q;
        instr_err_o     = rsp && !win_data_q && err_q;
        data_err_o      = rsp && win_data_q && err_q;
        instr_rdata_o   = (rsp && !win_data_q) ? rdata_q : '0;
        data_rdata_o    = (rsp && win_data_q) ? rdata_q : '0;
        addr_o          = addr_q;
        be_o            = be_q;
        wdata_o         = wdata_q;
        mask_o          = mask_q;
        funct_o         = funct_q;
    end

endmodule

// File: tb/tb_rt_mem_ctrl.sv
// tb/tb_rt_mem_ctrl.sv - randomized self-checking bench for rt_mem_ctrl against a transaction timeline model
`timescale 1ns/1ps
module tb_rt_mem_ctrl;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk_i = 1'b0;
    logic          rstn_i = 1'b0;
    logic          instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [AW-1:0] instr_addr_i;
    logic [DW-1:0] instr_rdata_o;
    logic          data_req_i, data_we_i, data_range_i, data_gnt_o, data_rvalid_o, data_err_o;
    logic [AW-1:0] data_addr_i;
    logic [3:0]    data_be_i;
    logic [DW-1:0] data_wdata_i, data_mask_i, data_rdata_o;
    logic [2:0]    data_funct_i;
    logic          en_ab_o, clk_m_o, Bz_s_o, write_pulse_o, read_pulse_o, write_en_data_o, range_active_o;
    logic [AW-1:0] addr_o;
    logic [3:0]    be_o;
    logic [DW-1:0] wdata_o, mask_o;
    logic [2:0]    funct_o;
    logic [DW-1:0] r_data_i;
    logic          r_valid_i;

    always #5 clk_i = ~clk_i;

    rt_mem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(2), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
        .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_wdata_i(data_wdata_i), .data_mask_i(data_mask_i), .data_funct_i(data_funct_i),
        .data_range_i(data_range_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
        .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .en_ab_o(en_ab_o), .clk_m_o(clk_m_o), .Bz_s_o(Bz_s_o), .write_pulse_o(write_pulse_o),
        .read_pulse_o(read_pulse_o), .write_en_data_o(write_en_data_o), .range_active_o(range_active_o),
        .addr_o(addr_o), .be_o(be_o), .wdata_o(wdata_o), .mask_o(mask_o), .funct_o(funct_o),
        .r_data_i(r_data_i), .r_valid_i(r_valid_i)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // pending requests per port (0 = instr, 1 = data)
    bit            pend [2];
    logic [AW-1:0] p_addr [2];
    logic          p_we [2];
    logic [3:0]    p_be [2];
    logic [DW-1:0] p_wdata [2];
    logic [DW-1:0] p_mask [2];
    logic [2:0]    p_funct [2];
    logic          p_range [2];
    int            p_k [2];      // cycles after ACCESS until r_valid_i; > TO means never
    logic [DW-1:0] p_rdata [2];

    // model of the transaction in flight
    bit            busy = 0;
    int            t = 0;        // cycles since grant
    int            win = 0;
    int            last_win = 0;
    int            clr_port = -1;
    logic [AW-1:0] c_addr;
    logic          c_we, c_range, c_err;
    logic [3:0]    c_be;
    logic [DW-1:0] c_wdata, c_mask, c_vdata, c_rdata;
    logic [2:0]    c_funct;
    int            c_k, c_n, c_A, c_B, c_R;

    bit rand_en = 0;
    bit cont_en = 0;
    bit chk_en = 0;

    // observations of DUT behaviour for the literal checks
    int            gnt_log [$];
    int            obs_wp, obs_rp, obs_rv, obs_fwd, obs_back;
    logic          obs_err;
    logic [DW-1:0] obs_rdata;

    task automatic new_req(input int p);
        pend[p]    = 1'b1;
        p_addr[p]  = AW'($urandom);
        p_we[p]    = (p == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        p_be[p]    = (p == 1) ? 4'($urandom) : 4'hF;
        p_wdata[p] = (p == 1) ? DW'($urandom) : '0;
        p_mask[p]  = (p == 1) ? DW'($urandom) : '1;
        p_funct[p] = (p == 1) ? 3'($urandom) : 3'd0;
        p_range[p] = (p == 1) ? 1'($urandom) : 1'b0;
        p_k[p]     = ($urandom_range(0, 7) == 0) ? TO + 1 : int'($urandom_range(0, TO));
        p_rdata[p] = DW'($urandom);
    endtask

    task automatic set_dir(input int p, input logic [AW-1:0] a, input logic we, input logic [DW-1:0] wd,
                           input logic [DW-1:0] mk, input logic [2:0] fn, input logic rg,
                           input int k, input logic [DW-1:0] rd);
        pend[p]    = 1'b1;
        p_addr[p]  = a;
        p_we[p]    = we;
        p_be[p]    = 4'hF;
        p_wdata[p] = wd;
        p_mask[p]  = mk;
        p_funct[p] = fn;
        p_range[p] = rg;
        p_k[p]     = k;
        p_rdata[p] = rd;
    endtask

    task automatic apply_inputs();
        instr_req_i  = pend[0];
        instr_addr_i = p_addr[0];
        data_req_i   = pend[1];
        data_addr_i  = p_addr[1];
        data_we_i    = p_we[1];
        data_be_i    = p_be[1];
        data_wdata_i = p_wdata[1];
        data_mask_i  = p_mask[1];
        data_funct_i = p_funct[1];
        data_range_i = p_range[1];
        if (busy && !c_we && !c_err && t == c_A + c_k) begin
            r_valid_i = 1'b1;
            r_data_i  = c_vdata;
        end else if (busy && t <= 2 * c_n && $urandom_range(0, 3) == 0) begin
            r_valid_i = 1'b1;       // stray valid before ACCESS must be ignored
            r_data_i  = DW'($urandom);
        end else begin
            r_valid_i = 1'b0;
            r_data_i  = DW'($urandom);
        end
    endtask

    // one clock: retire/advance the model, create requests, decide the grant, drive inputs
    task automatic step();
        @(posedge clk_i);
        #1;
        if (clr_port >= 0) pend[clr_port] = 1'b0;
        clr_port = -1;
        if (busy) begin
            t++;
            if (t > c_R) busy = 0;
        end
        if (rand_en) begin
            for (int p = 0; p < 2; p++) if (!pend[p] && $urandom_range(0, 2) == 0) new_req(p);
        end
        if (cont_en) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p]) begin
                    new_req(p);
                    p_we[p] = 1'b0;
                    p_addr[p][1:0] = 2'b00;
                    p_k[p] = 0;
                end
            end
        end
        if (!busy && (pend[0] || pend[1])) begin
            if (pend[0] && pend[1]) win = (last_win == 0) ? 1 : 0;
            else win = pend[1] ? 1 : 0;
            last_win = win;
            clr_port = win;
            busy     = 1;
            t        = 0;
            c_addr   = p_addr[win];
            c_we     = p_we[win];
            c_be     = p_be[win];
            c_wdata  = p_wdata[win];
            c_mask   = p_mask[win];
            c_funct  = p_funct[win];
            c_range  = p_range[win];
            c_k      = p_k[win];
            c_vdata  = p_rdata[win];
            c_n      = int'(c_addr[1:0]);
            c_A      = 2 * c_n + 1;
            c_err    = !c_we && (c_k > TO);
            if (c_we) c_B = c_A + 1;
            else if (c_err) c_B = c_A + TO + 1;
            else c_B = c_A + ((c_k < 1) ? 1 : c_k) + 1;
            c_R      = c_B + 2 * c_n;
            c_rdata  = (c_we || c_err) ? '0 : c_vdata;
        end
        apply_inputs();
    endtask

    task automatic drain();
        int n = 0;
        while ((busy || pend[0] || pend[1]) && n < 3000) begin
            step();
            n++;
        end
        chk("drain_done", {busy, pend[0], pend[1]}, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, {instr_gnt_o, data_gnt_o}, 0);
        chk({tag, "_strobes"}, {en_ab_o, clk_m_o, Bz_s_o, write_pulse_o, read_pulse_o, write_en_data_o, range_active_o}, 0);
        chk({tag, "_resp"}, {instr_rvalid_o, instr_err_o, data_rvalid_o, data_err_o}, 0);
        chk({tag, "_rdata"}, instr_rdata_o | data_rdata_o, 0);
        chk({tag, "_addr_be_funct"}, {addr_o, be_o, funct_o}, 0);
        chk({tag, "_wdata"}, wdata_o, 0);
        chk({tag, "_mask"}, mask_o, 0);
    endtask

    // per-cycle compare against the timeline model
    bit m_g, m_act, m_fwd, m_back, m_rsp, m_clk;
    always @(negedge clk_i) begin
        if (chk_en) begin
            m_g    = busy && t == 0;
            m_act  = busy && t >= 1;
            m_fwd  = m_act && t <= 2 * c_n;
            m_back = m_act && t >= c_B && t < c_B + 2 * c_n;
            m_rsp  = busy && t == c_R;
            m_clk  = (m_fwd && ((t - 1) % 2 == 0)) || (m_back && ((t - c_B) % 2 == 0));
            chk("instr_gnt", instr_gnt_o, m_g && win == 0);
            chk("data_gnt", data_gnt_o, m_g && win == 1);
            chk("en_ab", en_ab_o, m_act);
            chk("clk_m", clk_m_o, m_clk);
            chk("bz_s", Bz_s_o, m_fwd);
            chk("write_pulse", write_pulse_o, m_act && c_we && t == c_A);
            chk("write_en_data", write_en_data_o, m_act && c_we && t == c_A);
            chk("read_pulse", read_pulse_o, m_act && !c_we && t == c_A);
            chk("instr_rvalid", instr_rvalid_o, m_rsp && win == 0);
            chk("data_rvalid", data_rvalid_o, m_rsp && win == 1);
            chk("instr_err", instr_err_o, m_rsp && win == 0 && c_err);
            chk("data_err", data_err_o, m_rsp && win == 1 && c_err);
            chk("instr_rdata", instr_rdata_o, (m_rsp && win == 0) ? c_rdata : '0);
            chk("data_rdata", data_rdata_o, (m_rsp && win == 1) ? c_rdata : '0);
`ifdef RT_CTRL_LIM_EN
            chk("range_active", range_active_o, m_act && c_range);
`else
            chk("range_active", range_active_o, 0);
`endif
            if (m_act) begin
                chk("addr_o", addr_o, c_addr);
                chk("wdata_o", wdata_o, c_wdata);
                if (win == 1) chk("be_o", be_o, c_be);
`ifdef RT_CTRL_LIM_EN
                chk("mask_o", mask_o, c_mask);
                chk("funct_o", funct_o, c_funct);
`else
                chk("mask_o", mask_o, {DW{1'b1}});
                chk("funct_o", funct_o, 0);
`endif
            end
            if (m_g) begin
                obs_wp = -1; obs_rp = -1; obs_rv = -1; obs_fwd = 0; obs_back = 0;
                obs_err = 1'b0; obs_rdata = '0;
            end
            if (instr_gnt_o || data_gnt_o) gnt_log.push_back(data_gnt_o ? 1 : 0);
            if (write_pulse_o && obs_wp < 0) obs_wp = t;
            if (read_pulse_o && obs_rp < 0) obs_rp = t;
            if (clk_m_o && Bz_s_o) obs_fwd++;
            if (clk_m_o && !Bz_s_o) obs_back++;
            if (instr_rvalid_o || data_rvalid_o) begin
                obs_rv    = t;
                obs_rdata = instr_rdata_o | data_rdata_o;
                obs_err   = instr_err_o | data_err_o;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int gl_base;
    initial begin
        for (int p = 0; p < 2; p++) new_req(p);
        apply_inputs();
        rstn_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #3;
        chk_all_zero("reset");
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        apply_inputs();
        rstn_i = 1'b1;
        chk_en = 1;

        // both ports requesting continuously: data wins first tie, then alternation
        cont_en = 1;
        for (int n = 0; n < 200 && gnt_log.size() < 4; n++) step();
        cont_en = 0;
        drain();
        chk("arb_gnt_count", (gnt_log.size() >= 4), 1);
        if (gnt_log.size() >= 4) begin
            chk("arb_gnt0", gnt_log[0], 1);
            chk("arb_gnt1", gnt_log[1], 0);
            chk("arb_gnt2", gnt_log[2], 1);
            chk("arb_gnt3", gnt_log[3], 0);
        end

        // write, n = 0, carrying LiM operands
        set_dir(1, 8'h10, 1'b1, 32'hA5A5A5A5, 32'h0000FFFF, 3'd3, 1'b1, 0, 32'h0);
        step();
        step();
`ifdef RT_CTRL_LIM_EN
        chk("lim_funct", funct_o, 3);
        chk("lim_mask", mask_o, 32'h0000FFFF);
        chk("lim_range", range_active_o, 1);
`else
        chk("nolim_funct", funct_o, 0);
        chk("nolim_mask", mask_o, 32'hFFFFFFFF);
        chk("nolim_range", range_active_o, 0);
`endif
        drain();
        chk("wr_pulse_cycle", obs_wp, 1);
        chk("wr_rvalid_cycle", obs_rv, 2);
        chk("wr_err", obs_err, 0);
        chk("wr_rdata", obs_rdata, 0);

        // read, n = 3, valid one cycle after ACCESS
        set_dir(1, 8'h13, 1'b0, 32'h0, 32'hFFFFFFFF, 3'd0, 1'b0, 1, 32'hDEADBEEF);
        drain();
        chk("rd_fwd_pulses", obs_fwd, 3);
        chk("rd_pulse_cycle", obs_rp, 7);
        chk("rd_back_pulses", obs_back, 3);
        chk("rd_rvalid_cycle", obs_rv, 15);
        chk("rd_rdata", obs_rdata, 32'hDEADBEEF);
        chk("rd_err", obs_err, 0);

        // read, n = 1, valid never arrives
        set_dir(1, 8'h21, 1'b0, 32'h0, 32'hFFFFFFFF, 3'd0, 1'b0, TO + 1, 32'h12345678);
        drain();
        chk("to_rvalid_cycle", obs_rv, 22);
        chk("to_err", obs_err, 1);
        chk("to_rdata", obs_rdata, 0);

        // reset during the second forward shift pulse
        set_dir(1, 8'h12, 1'b0, 32'h0, 32'hFFFFFFFF, 3'd0, 1'b0, 0, 32'h0BADF00D);
        repeat (4) step();
        #1;
        chk_en = 0;
        chk("pre_rst_clk_m", clk_m_o, 1);
        instr_req_i = 1'b1;
        rstn_i = 1'b0;
        #1;
        chk_all_zero("mid_rst");
        @(posedge clk_i);
        #2;
        chk_all_zero("mid_rst_hold");
        busy = 0;
        last_win = 0;
        clr_port = -1;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        apply_inputs();
        rstn_i = 1'b1;
        chk_en = 1;

        // after reset the last-grant flag is instr again, so data wins a tie
        gl_base = gnt_log.size();
        set_dir(0, 8'h40, 1'b0, 32'h0, 32'hFFFFFFFF, 3'd0, 1'b0, 2, 32'h11112222);
        set_dir(1, 8'h44, 1'b0, 32'h0, 32'hFFFFFFFF, 3'd0, 1'b0, 0, 32'h33334444);
        drain();
        chk("post_rst_gnts", gnt_log.size() - gl_base, 2);
        if (gnt_log.size() >= gl_base + 2) begin
            chk("post_rst_first", gnt_log[gl_base], 1);
            chk("post_rst_second", gnt_log[gl_base + 1], 0);
        end

        // randomized traffic
        rand_en = 1;
        repeat (4000) step();
        rand_en = 0;
        drain();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
